// File: rtl/pipe_hazard_ctrl_pkg.sv
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Purpose  : Shared opcodes, forwarding-select encodings and FSM state type
//            for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    JFLUSH = 1'b1
  } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// ============================================================================
// Module   : pipe_fwd_sel
// Purpose  : Selects the ALU operand source for one EX source register;
//            the nearer EX/MEM producer wins over MEM/WB, r0 never forwards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic       force_rf,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_wreg,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_wreg,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (force_rf) begin
      sel = FWD_RF;
    end else if (mem_regwrite && (mem_wreg != 5'd0) && (mem_wreg == src_reg)) begin
      sel = FWD_EXMEM;
    end else if (wb_regwrite && (wb_wreg != 5'd0) && (wb_wreg == src_reg)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/flush/forward control for a 5-stage pipeline. Define
//            HAZ_FORWARD_EN for forwarding; otherwise RAW hazards stall.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int JUMP_STALL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic        ex_memread,
  input  logic        ex_alusrc,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_wreg,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_wreg,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_wreg,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cycles
);

  localparam logic [2:0] C_JCNT_LOAD = 3'(JUMP_STALL_CYCLES - 1);

  hz_state_t   r_state;
  hz_state_t   w_state_nxt;
  logic [2:0]  r_jcnt;
  logic [2:0]  w_jcnt_nxt;
  logic [15:0] r_stall_cycles;
  logic        w_is_jump;
  logic        w_load_use;
  logic        w_hazard;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_unused;

  assign w_is_jump  = (id_opcode == OP_J);
  assign w_load_use = ex_memread && (ex_wreg != 5'd0) &&
                      ((ex_wreg == id_rs) || (ex_wreg == id_rt));

  pipe_fwd_sel u_fwd_a (
    .src_reg      (ex_rs),
    .force_rf     (1'b0),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .sel          (w_fwd_a)
  );

  pipe_fwd_sel u_fwd_b (
    .src_reg      (ex_rt),
    .force_rf     (ex_alusrc),
    .mem_regwrite (mem_regwrite),
    .mem_wreg     (mem_wreg),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .sel          (w_fwd_b)
  );

`ifdef HAZ_FORWARD_EN
  assign w_hazard = w_load_use;
  assign fwd_a    = reset ? w_fwd_a : FWD_RF;
  assign fwd_b    = reset ? w_fwd_b : FWD_RF;
  assign w_unused = ex_regwrite;
`else
  // WB producers are excluded: the register file writes before ID reads it.
  logic w_raw_rs;
  logic w_raw_rt;
  assign w_raw_rs = (id_rs != 5'd0) &&
                    ((ex_regwrite && (ex_wreg == id_rs)) ||
                     (mem_regwrite && (mem_wreg == id_rs)));
  assign w_raw_rt = (id_rt != 5'd0) &&
                    ((ex_regwrite && (ex_wreg == id_rt)) ||
                     (mem_regwrite && (mem_wreg == id_rt)));
  assign w_hazard = w_load_use || w_raw_rs || w_raw_rt;
  assign fwd_a    = FWD_RF;
  assign fwd_b    = FWD_RF;
  assign w_unused = ^{w_fwd_a, w_fwd_b};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_jcnt_nxt  = r_jcnt;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (r_state)
      RUN: begin
        if (w_is_jump) begin
          w_state_nxt = JFLUSH;
          w_jcnt_nxt  = C_JCNT_LOAD;
        end else if (w_hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      JFLUSH: begin
        ifid_flush = 1'b1;
        pc_write   = 1'b0;
        if (r_jcnt == 3'd0) begin
          w_state_nxt = RUN;
        end else begin
          w_jcnt_nxt = r_jcnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_jcnt_nxt  = 3'd0;
      end
    endcase
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RUN;
      r_jcnt         <= 3'd0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_jcnt  <= w_jcnt_nxt;
      if (!pc_write && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed vector table plus hand sequences for jump flush,
//            reset during flush and stall counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

`ifdef HAZ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
  logic        ex_memread, ex_alusrc, ex_regwrite, mem_regwrite, wb_regwrite;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt;
    logic       ex_memread, ex_alusrc, ex_regwrite;
    logic [4:0] ex_wreg;
    logic       mem_regwrite;
    logic [4:0] mem_wreg;
    logic       wb_regwrite;
    logic [4:0] wb_wreg;
    logic       stall_fwd, stall_nofwd;
    logic [1:0] fa, fb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg), .mem_regwrite(mem_regwrite),
    .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite), .wb_wreg(wb_wreg),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b};
  endfunction

  task automatic clear_inputs();
    id_opcode = OP_RTYPE; id_rs = 5'd0; id_rt = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    ex_memread = 1'b0; ex_alusrc = 1'b0; ex_regwrite = 1'b0; ex_wreg = 5'd0;
    mem_regwrite = 1'b0; mem_wreg = 5'd0; wb_regwrite = 1'b0; wb_wreg = 5'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    id_opcode = v.op; id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_memread = v.ex_memread; ex_alusrc = v.ex_alusrc; ex_regwrite = v.ex_regwrite;
    ex_wreg = v.ex_wreg; mem_regwrite = v.mem_regwrite; mem_wreg = v.mem_wreg;
    wb_regwrite = v.wb_regwrite; wb_wreg = v.wb_wreg;
  endtask

  // J in ID with a simultaneous load-use; J stays on ID throughout the flush.
  task automatic jump_seq(input string tag);
    logic [15:0] s0;
    @(posedge clk); #1;
    clear_inputs();
    id_opcode = OP_J; ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd1; id_rs = 5'd1;
    @(negedge clk);
    s0 = stall_cycles;
    check({tag, "_j_in_run"}, {24'd0, outs()}, 32'h0000_00C0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("%s_flush%0d", tag, i), {30'd0, pc_write, ifid_flush}, 32'd1);
    end
    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check({tag, "_run_after"}, {24'd0, outs()}, 32'h0000_00C0);
    check({tag, "_stall_delta"}, {16'd0, 16'(stall_cycles - s0)}, 32'd2);
  endtask

  initial begin
    int         exp_stalls;
    logic       st;
    logic [1:0] fa, fb;
    logic [7:0] exp;

    //          name          op        id_rs  id_rt  ex_rs  ex_rt  mrd   asrc  exrw  exw    memrw memw   wbrw  wbw    stF   stN   fa    fb
    vecs[0]  = '{"idle",       OP_RTYPE, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 2'd0, 2'd0};
    vecs[1]  = '{"lu_rs",      OP_RTYPE, 5'd1,  5'd7,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd1,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 2'd0};
    vecs[2]  = '{"lu_next",    OP_RTYPE, 5'd1,  5'd7,  5'd1,  5'd7,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd1,  1'b0, 5'd0,  1'b0, 1'b1, 2'd1, 2'd0};
    vecs[3]  = '{"lu_rt",      OP_LW,    5'd2,  5'd5,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 2'd0, 2'd0};
    vecs[4]  = '{"r0_load",    OP_RTYPE, 5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 2'd0, 2'd0};
    vecs[5]  = '{"double",     OP_RTYPE, 5'd0,  5'd0,  5'd3,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd3,  1'b1, 5'd3,  1'b0, 1'b0, 2'd1, 2'd0};
    vecs[6]  = '{"wb_only",    OP_RTYPE, 5'd4,  5'd0,  5'd4,  5'd4,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd4,  1'b0, 1'b0, 2'd2, 2'd2};
    vecs[7]  = '{"alusrc",     OP_XORI,  5'd0,  5'd0,  5'd6,  5'd6,  1'b0, 1'b1, 1'b0, 5'd0,  1'b1, 5'd6,  1'b0, 5'd0,  1'b0, 1'b0, 2'd1, 2'd0};
    vecs[8]  = '{"mem_off",    OP_RTYPE, 5'd0,  5'd0,  5'd6,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd6,  1'b1, 5'd6,  1'b0, 1'b0, 2'd2, 2'd0};
    vecs[9]  = '{"fwd_r0",     OP_RTYPE, 5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 2'd0, 2'd0};
    vecs[10] = '{"ex_raw",     OP_RTYPE, 5'd0,  5'd9,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 5'd9,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 2'd0, 2'd0};
    vecs[11] = '{"no_match",   OP_SW,    5'd2,  5'd3,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 2'd0, 2'd0};
    vecs[12] = '{"mem_raw_rt", OP_RTYPE, 5'd0,  5'd10, 5'd0,  5'd10, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd10, 1'b0, 5'd0,  1'b0, 1'b1, 2'd0, 2'd1};
    vecs[13] = '{"fb_wb",      OP_RTYPE, 5'd0,  5'd0,  5'd12, 5'd11, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 5'd12, 1'b1, 5'd11, 1'b0, 1'b0, 2'd1, 2'd2};

    // Reset with hazard and forwarding conditions present on the inputs.
    clear_inputs();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd1; id_rs = 5'd1;
    mem_regwrite = 1'b1; mem_wreg = 5'd3; ex_rs = 5'd3;
    #12;
    check("reset_outs", {24'd0, outs()}, 32'h0000_0030);
    check("reset_count", {16'd0, stall_cycles}, 32'd0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;

    exp_stalls = 0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive_vec(vecs[i]);
      @(negedge clk);
      st  = FWD ? vecs[i].stall_fwd : vecs[i].stall_nofwd;
      fa  = FWD ? vecs[i].fa : 2'd0;
      fb  = FWD ? vecs[i].fb : 2'd0;
      exp = st ? {4'b0001, fa, fb} : {4'b1100, fa, fb};
      check(vecs[i].name, {24'd0, outs()}, {24'd0, exp});
      exp_stalls += int'(st);
    end
    @(posedge clk); #1;
    clear_inputs();
    check("table_stall_count", {16'd0, stall_cycles}, 32'(exp_stalls));

    jump_seq("jump");

    // Reset asserted during the first flush cycle.
    @(posedge clk); #1;
    id_opcode = OP_J;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_pre_flush", {30'd0, pc_write, ifid_flush}, 32'd1);
    #1;
    reset = 1'b0;
    mem_regwrite = 1'b1; mem_wreg = 5'd2; ex_rs = 5'd2;
    #1;
    check("rst_mid_outs", {24'd0, outs()}, 32'h0000_0030);
    check("rst_mid_count", {16'd0, stall_cycles}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_resume_run", {24'd0, outs()}, 32'h0000_00C0);
    jump_seq("post_rst");

    // Hold a load-use stall long enough to saturate the counter.
    @(posedge clk); #1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wreg = 5'd1; id_rs = 5'd1;
    repeat (65540) @(posedge clk);
    #1;
    check("sat_count", {16'd0, stall_cycles}, 32'h0000_FFFF);
    @(posedge clk); #1;
    check("sat_hold", {16'd0, stall_cycles}, 32'h0000_FFFF);
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter JUMP_STALL_CYCLES, default 2, sets the number of IF/ID flush cycles after a jump is decoded in ID (legal range 1..7).
REQ-002 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous, active-low reset.
REQ-004 Port id_opcode, input, 6, opcode [31:26] of the instruction in the IF/ID register.
REQ-005 Ports id_rs and id_rt, input, 5 each, the source register fields of the instruction in ID.
REQ-006 Ports ex_rs and ex_rt, input, 5 each, the source registers held in ID/EX.
REQ-007 Ports ex_memread and ex_alusrc, input, 1 each, ID/EX control bits.
REQ-008 Ports ex_regwrite and ex_wreg, input, 1 and 5, the ID/EX destination.
REQ-009 Ports mem_regwrite and mem_wreg, input, 1 and 5, the EX/MEM destination.
REQ-010 Ports wb_regwrite and wb_wreg, input, 1 and 5, the MEM/WB destination.
REQ-011 Port pc_write, output, 1; 1 means the PC may update.
REQ-012 Port ifid_write, output, 1; 1 means IF/ID may load.
REQ-013 Port ifid_flush, output, 1; 1 means IF/ID loads a noop (all fields zero).
REQ-014 Port idex_bubble, output, 1; 1 means ID/EX control bits are forced to zero.
REQ-015 Ports fwd_a and fwd_b, output, 2 each, ALU operand select: 0 = register file, 1 = EX/MEM ALU result, 2 = MEM/WB result.
REQ-016 Port stall_cycles, output, 16, a saturating count of cycles in which pc_write was 0.

Function
REQ-017 The FSM SHALL have exactly two states, RUN and JFLUSH, plus a flush counter jcnt of 3 bits.
REQ-018 In RUN, when id_opcode equals 6'b000010 (J), the next state SHALL be JFLUSH and jcnt SHALL be loaded with JUMP_STALL_CYCLES-1.
REQ-019 In JFLUSH the block SHALL drive ifid_flush=1 and pc_write=0.
  - jcnt decrements each cycle.
  - When jcnt==0 the next state SHALL be RUN.
  - Total flush length is exactly JUMP_STALL_CYCLES cycles.
REQ-020 A J opcode in ID during JFLUSH SHALL be ignored, because ID holds a flushed noop.
REQ-021 A load-use hazard SHALL be declared, combinationally in RUN, when all of the following hold:
  - ex_memread=1;
  - ex_wreg!=0;
  - ex_wreg==id_rs, or ex_wreg==id_rt;
  - id_opcode is not J.
REQ-022 On a load-use hazard the block SHALL drive pc_write=0, ifid_write=0 and idex_bubble=1 for that cycle only. The next cycle re-evaluates with the bubble in EX.
REQ-023 When the ID opcode is J and a load-use condition also holds, the J handling SHALL take priority and no bubble SHALL be inserted.
REQ-024 fwd_a SHALL be selected as follows:
  - 1 if mem_regwrite and mem_wreg!=0 and mem_wreg==ex_rs;
  - else 2 if wb_regwrite and wb_wreg!=0 and wb_wreg==ex_rs;
  - else 0.
REQ-025 fwd_b SHALL apply the same rule on ex_rt, and SHALL be forced to 0 when ex_alusrc=1.
REQ-026 Register 0 SHALL never cause a stall or a forward.
REQ-027 Outside hazard and flush conditions the block SHALL drive pc_write=1, ifid_write=1, ifid_flush=0 and idex_bubble=0.
REQ-028 stall_cycles SHALL increment on each rising edge where pc_write=0, and SHALL hold at 16'hFFFF.

Reset
REQ-029 While reset=0 the block SHALL be in state RUN with jcnt=0 and stall_cycles=0.
REQ-030 While reset=0 the outputs SHALL be pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, fwd_a=0 and fwd_b=0.
REQ-031 Reset asserted mid-JFLUSH SHALL abort the flush immediately, and after release the FSM SHALL resume in RUN.

Configuration
REQ-032 With HAZ_FORWARD_EN defined, the block SHALL behave as specified in REQ-022 and REQ-024..025.
REQ-033 Without HAZ_FORWARD_EN, fwd_a and fwd_b SHALL be tied to 0, and any RAW hazard SHALL stall using the REQ-022 outputs. A RAW hazard exists when id_rs or id_rt (non-zero) matches either of:
  - ex_wreg with ex_regwrite=1;
  - mem_wreg with mem_regwrite=1.
  A WB match SHALL NOT stall, since the register file writes on posedge and reads on negedge.

Structure
REQ-034 A shared package SHALL hold:
  - opcode constants: J=6'b000010, LW=6'b100011, SW=6'b101011, RTYPE=6'b000000, XORI=6'b001110;
  - the forwarding-select encodings FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2;
  - the FSM state type.
REQ-035 The forwarding comparator SHALL be a single sub-module, pipe_fwd_sel, instantiated once per operand.

Verification
REQ-036 Load-use: EX holds lw r1 (ex_memread=1, ex_wreg=1) and ID holds sub r2,r1,r7 (id_rs=1). Required: one cycle of pc_write=0 and idex_bubble=1; the following cycle, with mem_wreg=1 and ex_rs=1, gives fwd_a=1.
REQ-037 Jump: id_opcode=6'b000010 with default parameter. Required: ifid_flush=1 and pc_write=0 for exactly 2 cycles, then RUN; stall_cycles increases by 2.
REQ-038 Double match: mem_wreg=wb_wreg=3 with ex_rs=3 and both regwrites set. Required: fwd_a=1 (EX/MEM wins).
REQ-039 Register 0 and immediates: ex_memread=1 with ex_wreg=0 and id_rs=0 gives no stall; ex_alusrc=1 with a matching ex_rt gives fwd_b=0.
REQ-040 Reset: assert reset at the first JFLUSH cycle. Required: outputs immediately take their REQ-030 values and stall_cycles=0; after release, the next J yields a full 2-cycle flush.
REQ-041 Saturation: preload the counter via 65540 stall cycles. Required: stall_cycles=16'hFFFF.
